// File: rtl/uart_pkg.sv
// Shared definitions for the UART register-bus sequencer: FSM encoding and
// 16750 register map.
package uart_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        STROBE,
        RESP
    } seq_state_t;

    localparam logic [2:0] RBR_THR_DLL = 3'd0;
    localparam logic [2:0] IER_DLM     = 3'd1;
    localparam logic [2:0] FCR         = 3'd2;
    localparam logic [2:0] LCR         = 3'd3;
    localparam logic [2:0] MCR         = 3'd4;
    localparam logic [2:0] LSR         = 3'd5;
    localparam logic [2:0] MSR         = 3'd6;
    localparam logic [2:0] SCR         = 3'd7;

    localparam int LCR_DLAB = 7;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter; grant is valid only while enable is high and
// last_grant advances whenever a grant is issued.
module uart_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Reset to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/uart_bus_sequencer.sv
// Owns the UART register bus: runs the power-on init writes, then serves two
// requesters round-robin with one registered transaction in flight.
module uart_bus_sequencer
    import uart_pkg::*;
#(
    parameter logic [15:0] DIVISOR  = 16'd12,
    parameter logic [7:0]  LCR_INIT = 8'h03,
    parameter logic [7:0]  FCR_INIT = 8'h07,
    parameter logic [7:0]  MCR_INIT = 8'h03,
    parameter logic [7:0]  IER_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [2:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [2:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic [2:0] u_address,
    output logic       u_write,
    output logic       u_read,
    output logic [7:0] u_writedata,
    output logic       u_cs,
    input  logic [7:0] u_readdata,
    output logic       init_done
);

    localparam logic [7:0] DLAB_MASK = 8'(1 << LCR_DLAB);

    function automatic logic [10:0] init_word(input logic [2:0] s);
        case (s)
            3'd0:    init_word = {LCR,         LCR_INIT | DLAB_MASK};
            3'd1:    init_word = {RBR_THR_DLL, DIVISOR[7:0]};
            3'd2:    init_word = {IER_DLM,     DIVISOR[15:8]};
            3'd3:    init_word = {LCR,         LCR_INIT & ~DLAB_MASK};
            3'd4:    init_word = {FCR,         FCR_INIT};
            3'd5:    init_word = {MCR,         MCR_INIT};
            default: init_word = {IER_DLM,     IER_INIT};
        endcase
    endfunction

    seq_state_t state, state_nxt;
    logic [2:0] step, step_nxt;
    logic       gnt_m1_p0, gnt_m1_nxt;
    logic       rd_p0, rd_nxt;
    logic [1:0] req, grant;
    logic       cs_nxt, write_nxt, read_nxt, done_nxt;
    logic       m0_ack_nxt, m1_ack_nxt;
    logic [2:0] addr_nxt;
    logic [7:0] wdata_nxt, m0_rdata_nxt, m1_rdata_nxt;

    // A requester whose ack is showing is masked so a held req is not re-served.
    assign req = {m1_req & ~m1_ack, m0_req & ~m0_ack};

    uart_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .enable (state == IDLE),
        .grant  (grant)
    );

    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        gnt_m1_nxt   = gnt_m1_p0;
        rd_nxt       = rd_p0;
        cs_nxt       = 1'b0;
        write_nxt    = 1'b0;
        read_nxt     = 1'b0;
        addr_nxt     = u_address;
        wdata_nxt    = u_writedata;
        done_nxt     = init_done;
        m0_ack_nxt   = 1'b0;
        m1_ack_nxt   = 1'b0;
        m0_rdata_nxt = m0_rdata;
        m1_rdata_nxt = m1_rdata;
        case (state)
            INIT: begin
                if (step == 3'd7) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cs_nxt                = 1'b1;
                    write_nxt             = 1'b1;
                    {addr_nxt, wdata_nxt} = init_word(step);
                    step_nxt              = step + 3'd1;
                end
            end
            IDLE: begin
                if (|grant) begin
                    gnt_m1_nxt = grant[1];
                    rd_nxt     = grant[1] ? ~m1_we : ~m0_we;
                    addr_nxt   = grant[1] ? m1_addr : m0_addr;
                    wdata_nxt  = grant[1] ? m1_wdata : m0_wdata;
                    cs_nxt     = 1'b1;
                    write_nxt  = ~rd_nxt;
                    read_nxt   = rd_nxt;
                    state_nxt  = STROBE;
                end
            end
            STROBE: state_nxt = RESP;
            RESP: begin
                // UART read data is valid this cycle; capture it alongside ack.
                if (gnt_m1_p0) begin
                    m1_ack_nxt = 1'b1;
                    if (rd_p0) m1_rdata_nxt = u_readdata;
                end else begin
                    m0_ack_nxt = 1'b1;
                    if (rd_p0) m0_rdata_nxt = u_readdata;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= INIT;
            step        <= 3'd0;
            gnt_m1_p0   <= 1'b0;
            rd_p0       <= 1'b0;
            u_cs        <= 1'b0;
            u_write     <= 1'b0;
            u_read      <= 1'b0;
            u_address   <= 3'd0;
            u_writedata <= 8'd0;
            init_done   <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= 8'd0;
            m1_rdata    <= 8'd0;
        end else begin
            state       <= state_nxt;
            step        <= step_nxt;
            gnt_m1_p0   <= gnt_m1_nxt;
            rd_p0       <= rd_nxt;
            u_cs        <= cs_nxt;
            u_write     <= write_nxt;
            u_read      <= read_nxt;
            u_address   <= addr_nxt;
            u_writedata <= wdata_nxt;
            init_done   <= done_nxt;
            m0_ack      <= m0_ack_nxt;
            m1_ack      <= m1_ack_nxt;
            m0_rdata    <= m0_rdata_nxt;
            m1_rdata    <= m1_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Scoreboard bench for uart_bus_sequencer: expected strobes and acks are queued
// as stimulus is driven and matched as the DUT produces them.
module tb_uart_bus_sequencer;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
        logic       we;
    } strb_t;

    typedef struct packed {
        logic       who;
        logic [7:0] rdata;
    } ack_t;

    logic       clk, reset;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [2:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;
    logic       m0_ack, m1_ack;
    logic [7:0] m0_rdata, m1_rdata;
    logic [2:0] u_address;
    logic       u_write, u_read, u_cs, init_done;
    logic [7:0] u_writedata, u_readdata;

    logic [7:0] rd_val [8];
    logic [7:0] rd_exp [2];
    strb_t      exp_strb[$];
    ack_t       exp_ack[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int strobe_cnt = 0;
    bit strobe_now;
    logic [1:0] ack_now;

    uart_bus_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .m0_req      (m0_req),
        .m0_we       (m0_we),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_ack      (m0_ack),
        .m0_rdata    (m0_rdata),
        .m1_req      (m1_req),
        .m1_we       (m1_we),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_ack      (m1_ack),
        .m1_rdata    (m1_rdata),
        .u_address   (u_address),
        .u_write     (u_write),
        .u_read      (u_read),
        .u_writedata (u_writedata),
        .u_cs        (u_cs),
        .u_readdata  (u_readdata),
        .init_done   (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: read data registered on the strobe edge
    always @(posedge clk or posedge reset) begin
        if (reset) u_readdata <= 8'd0;
        else if (u_cs && u_read) u_readdata <= rd_val[u_address];
    end

    task automatic step_cycle();
        strb_t es;
        ack_t  ea;
        logic [7:0] got_rd;
        @(negedge clk);
        cyc++;
        strobe_now = 1'b0;
        ack_now    = 2'b00;
        if (u_cs) begin
            strobe_now = 1'b1;
            strobe_cnt++;
            n_checks++;
            if (exp_strb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_strobe unexpected at cyc %0d: addr=%0d data=%02h wr=%0b rd=%0b",
                         cyc, u_address, u_writedata, u_write, u_read);
            end else begin
                es = exp_strb.pop_front();
                if ({u_address, u_writedata, u_write, u_read} !== {es.addr, es.data, es.we, ~es.we}) begin
                    n_fail++;
                    $display("FAIL sb_strobe cyc %0d: got addr=%0d data=%02h wr=%0b rd=%0b, want addr=%0d data=%02h wr=%0b",
                             cyc, u_address, u_writedata, u_write, u_read, es.addr, es.data, es.we);
                end
            end
        end
        if (m0_ack || m1_ack) begin
            ack_now = {m1_ack, m0_ack};
            n_checks++;
            if (m0_ack && m1_ack) begin
                n_fail++;
                $display("FAIL ack_overlap cyc %0d: m0_ack=1 m1_ack=1, want one", cyc);
            end else if (exp_ack.size() == 0) begin
                n_fail++;
                $display("FAIL sb_ack unexpected at cyc %0d: m0_ack=%0b m1_ack=%0b", cyc, m0_ack, m1_ack);
            end else begin
                ea = exp_ack.pop_front();
                got_rd = m1_ack ? m1_rdata : m0_rdata;
                if ({m1_ack, got_rd} !== {ea.who, ea.rdata}) begin
                    n_fail++;
                    $display("FAIL sb_ack cyc %0d: got m%0d rdata=%02h, want m%0d rdata=%02h",
                             cyc, m1_ack, got_rd, ea.who, ea.rdata);
                end
            end
        end
    endtask

    task automatic push_init();
        strb_t s;
        logic [10:0] seq [7];
        seq = '{{3'd3, 8'h83}, {3'd0, 8'h0C}, {3'd1, 8'h00}, {3'd3, 8'h03},
                {3'd2, 8'h07}, {3'd4, 8'h03}, {3'd1, 8'h00}};
        for (int i = 0; i < 7; i++) begin
            s.addr = seq[i][10:8];
            s.data = seq[i][7:0];
            s.we   = 1'b1;
            exp_strb.push_back(s);
        end
    endtask

    task automatic push_txn(input logic who, input logic we, input logic [2:0] addr, input logic [7:0] wd);
        strb_t s;
        ack_t  a;
        s.addr = addr;
        s.data = wd;
        s.we   = we;
        exp_strb.push_back(s);
        if (!we) rd_exp[who] = rd_val[addr];
        a.who   = who;
        a.rdata = rd_exp[who];
        exp_ack.push_back(a);
    endtask

    task automatic set_req(input logic who, input logic on, input logic we,
                           input logic [2:0] addr, input logic [7:0] wd);
        if (who) begin
            m1_req = on; m1_we = we; m1_addr = addr; m1_wdata = wd;
        end else begin
            m0_req = on; m0_we = we; m0_addr = addr; m0_wdata = wd;
        end
    endtask

    task automatic run_txn(input logic who, input logic we, input logic [2:0] addr,
                           input logic [7:0] wd, output int s_lat, output int a_lat);
        int start;
        push_txn(who, we, addr, wd);
        set_req(who, 1'b1, we, addr, wd);
        start = cyc;
        s_lat = -1;
        a_lat = -1;
        for (int i = 0; i < 12; i++) begin
            step_cycle();
            if (strobe_now && s_lat < 0) s_lat = cyc - start;
            if (ack_now[who]) begin
                a_lat = cyc - start;
                break;
            end
        end
        set_req(who, 1'b0, we, addr, wd);
        if (a_lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_timeout m%0d: no ack within 12 cycles, want ack", who);
        end
    endtask

    task automatic wait_init(output int done_lat, output int strobes);
        int start, s0;
        start = cyc;
        s0 = strobe_cnt;
        done_lat = -1;
        for (int i = 0; i < 20; i++) begin
            step_cycle();
            if (init_done) begin
                done_lat = cyc - start;
                break;
            end
        end
        strobes = strobe_cnt - s0;
    endtask

    task automatic test_reset();
        int dl, ns;
        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        step_cycle();
        step_cycle();
        n_checks++;
        if ({u_cs, u_write, u_read} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes got %03b want 000", {u_cs, u_write, u_read});
        end
        n_checks++;
        if ({u_address, u_writedata} !== 11'd0) begin
            n_fail++; $display("FAIL reset_bus got addr=%0d data=%02h want 0/00", u_address, u_writedata);
        end
        n_checks++;
        if ({m0_ack, m1_ack, init_done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ack_done got %03b want 000", {m0_ack, m1_ack, init_done});
        end
        n_checks++;
        if ({m0_rdata, m1_rdata} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_rdata got %02h/%02h want 00/00", m0_rdata, m1_rdata);
        end
        push_init();
        reset = 1'b0;
        wait_init(dl, ns);
        n_checks++;
        if (dl !== 8) begin
            n_fail++; $display("FAIL init_done_cycle got %0d want 8", dl);
        end
        n_checks++;
        if (ns !== 7 || exp_strb.size() !== 0) begin
            n_fail++; $display("FAIL init_writes got %0d strobes, %0d left, want 7/0", ns, exp_strb.size());
        end
    endtask

    task automatic test_m0_write();
        int sl, al;
        run_txn(1'b0, 1'b1, 3'd7, 8'hA5, sl, al);
        n_checks++;
        if (sl !== 1) begin
            n_fail++; $display("FAIL m0_write_strobe_lat got %0d want 1", sl);
        end
        n_checks++;
        if (al !== 3) begin
            n_fail++; $display("FAIL m0_write_ack_lat got %0d want 3", al);
        end
        for (int i = 0; i < 3; i++) step_cycle();
    endtask

    task automatic test_m1_read();
        int sl, al;
        rd_val[5] = 8'h60;
        run_txn(1'b1, 1'b0, 3'd5, 8'h00, sl, al);
        n_checks++;
        if (sl !== 1 || al !== 3) begin
            n_fail++; $display("FAIL m1_read_lat got strobe %0d ack %0d want 1/3", sl, al);
        end
        n_checks++;
        if (m0_rdata !== rd_exp[0]) begin
            n_fail++; $display("FAIL m1_read_m0_rdata got %02h want %02h", m0_rdata, rd_exp[0]);
        end
        n_checks++;
        if (m1_rdata !== 8'h60) begin
            n_fail++; $display("FAIL m1_read_rdata_hold got %02h want 60", m1_rdata);
        end
        for (int i = 0; i < 3; i++) step_cycle();
    endtask

    task automatic test_back_to_back();
        int prev, acks;
        rd_val[6] = 8'h9C;
        rd_val[2] = 8'h3E;
        for (int i = 0; i < 2; i++) begin
            push_txn(1'b0, 1'b0, 3'd6, 8'h00);
            push_txn(1'b1, 1'b0, 3'd2, 8'h00);
        end
        set_req(1'b0, 1'b1, 1'b0, 3'd6, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 3'd2, 8'h00);
        prev = -1;
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            step_cycle();
            if (strobe_now) begin
                if (prev >= 0) begin
                    n_checks++;
                    if (cyc - prev !== 3) begin
                        n_fail++; $display("FAIL rr_spacing got %0d want 3", cyc - prev);
                    end
                end
                prev = cyc;
            end
            if (ack_now != 2'b00) acks++;
            if (acks == 4) break;
        end
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        n_checks++;
        if (acks !== 4 || exp_ack.size() !== 0) begin
            n_fail++; $display("FAIL rr_acks got %0d acks, %0d pending, want 4/0", acks, exp_ack.size());
        end
        for (int i = 0; i < 4; i++) step_cycle();
    endtask

    task automatic test_req_during_init();
        int start, dl, sl;
        reset = 1'b1;
        rd_exp[0] = 8'h00;
        rd_exp[1] = 8'h00;
        step_cycle();
        push_init();
        push_txn(1'b0, 1'b1, 3'd7, 8'h3C);
        reset = 1'b0;
        start = cyc;
        step_cycle();
        step_cycle();
        set_req(1'b0, 1'b1, 1'b1, 3'd7, 8'h3C);
        dl = -1;
        sl = -1;
        for (int i = 0; i < 20; i++) begin
            step_cycle();
            if (init_done && dl < 0) dl = cyc - start;
            if (strobe_now && dl >= 0 && sl < 0) sl = cyc - start;
            if (ack_now[0]) break;
        end
        set_req(1'b0, 1'b0, 1'b1, 3'd7, 8'h3C);
        n_checks++;
        if (dl !== 8) begin
            n_fail++; $display("FAIL init_req_done got %0d want 8", dl);
        end
        n_checks++;
        if (sl !== 9) begin
            n_fail++; $display("FAIL init_req_strobe got %0d want 9", sl);
        end
        n_checks++;
        if (exp_strb.size() !== 0 || exp_ack.size() !== 0) begin
            n_fail++; $display("FAIL init_req_pending got %0d/%0d want 0/0", exp_strb.size(), exp_ack.size());
        end
        for (int i = 0; i < 3; i++) step_cycle();
    endtask

    task automatic test_reset_in_strobe();
        int dl, ns;
        bit seen;
        push_txn(1'b1, 1'b1, 3'd7, 8'h11);
        set_req(1'b1, 1'b1, 1'b1, 3'd7, 8'h11);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            step_cycle();
            seen = strobe_now;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL rst_strobe_seen got 0 want 1");
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({u_cs, u_write, u_read, init_done, m0_ack, m1_ack} !== 6'b0) begin
            n_fail++; $display("FAIL rst_async_clear got %06b want 000000",
                               {u_cs, u_write, u_read, init_done, m0_ack, m1_ack});
        end
        exp_strb.delete();
        exp_ack.delete();
        rd_exp[0] = 8'h00;
        rd_exp[1] = 8'h00;
        set_req(1'b1, 1'b0, 1'b1, 3'd7, 8'h11);
        for (int i = 0; i < 3; i++) step_cycle();
        push_init();
        reset = 1'b0;
        wait_init(dl, ns);
        n_checks++;
        if (dl !== 8 || ns !== 7) begin
            n_fail++; $display("FAIL rst_rerun_init got done %0d strobes %0d want 8/7", dl, ns);
        end
        for (int i = 0; i < 4; i++) step_cycle();
        n_checks++;
        if (exp_strb.size() !== 0 || exp_ack.size() !== 0) begin
            n_fail++; $display("FAIL rst_rerun_pending got %0d/%0d want 0/0", exp_strb.size(), exp_ack.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rd_val[i] = 8'h00;
        rd_exp[0] = 8'h00;
        rd_exp[1] = 8'h00;
        test_reset();
        test_m0_write();
        test_m1_read();
        test_back_to_back();
        test_req_during_init();
        test_reset_in_strobe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
